debug_beacon: RTL and testbench
===============================

// Module: debug_beacon
// PURPOSE
//  Parametrised periodic debug telemetry generator for the UART debug path.
//  Replaces the fixed single-byte heartbeat with a framed multi-channel packet.
//  Packet layout: sync byte, sequence number, length, status bytes, checksum.
//  A free-running period timer or an external trigger starts each packet.
//  Output is a byte stream with valid/ready handshake feeding the UART tx side of debug_port.
// PARAMETERS
//  PERIOD     8388608  cycles between automatic frames (>=2); timer width $clog2(PERIOD)
//  NUM_CH     4        status bytes per frame (1..255)
//  SYNC_BYTE  8'hA5    first byte of every frame
// PORTS
//  i_clk      in   1          system clock
//  i_rst      in   1          reset, asynchronous, active-low
//  i_en       in   1          1: period timer runs; 0: timer held at 0
//  i_trig     in   1          1-cycle pulse: request a frame now
//  i_status   in   NUM_CH*8   status bytes; CH0 = bits [7:0]
//  o_wdata    out  8          stream byte
//  o_wvalid   out  1          o_wdata valid
//  i_wready   in   1          sink accepts; transfer when o_wvalid & i_wready
//  o_busy     out  1          FSM not in IDLE
//  o_drops    out  8          saturating count of coalesced requests
// BEHAVIOUR
//  Reset (i_rst=0, async): timer=0, pending=0, seq=0, sum=0, state=IDLE.
//   Outputs during reset: o_wdata=0, o_wvalid=0, o_busy=0, o_drops=0.
//  Timer: while i_en, increments each cycle; at PERIOD-1 it wraps to 0 and asserts internal tick for 1 cycle.
//   When !i_en, the timer clears to 0 and no tick is produced.
//  Request: tick | i_trig sets the pending flag on the next edge.
//   If pending is already 1 when a request arrives, it is coalesced: o_drops += 1, saturating at 255.
//   tick and i_trig in the same cycle form one request.
//  States: IDLE, SYNC, SEQ, LEN, DATA, CHK.
//   IDLE -> SYNC when pending=1. On that edge: pending clears, i_status is snapshotted, sum=0, byte index=0.
//   Each non-IDLE state holds o_wvalid=1 and advances only on o_wvalid & i_wready.
//   SYNC: o_wdata=SYNC_BYTE.
//   SEQ: o_wdata=seq.
//   LEN: o_wdata=NUM_CH.
//   DATA: o_wdata=snapshot byte[idx], idx increments per transfer; idx==NUM_CH-1 accepted -> CHK.
//   CHK: o_wdata = (~sum)+1, i.e. SEQ+LEN+DATA+CHK == 0 mod 256.
//    On accept: seq = seq+1 mod 256 (255 wraps to 0); state -> IDLE.
//  sum: 8-bit, wraps; accumulates each accepted SEQ, LEN and DATA byte (SYNC excluded).
//  Handshake rules:
//   o_wdata is stable while o_wvalid & !i_wready.
//   o_wvalid never drops before a transfer.
//   No combinational path from i_wready to o_wvalid or o_wdata.
//  Latency: request at edge T -> pending at T+1 -> SYNC with o_wvalid=1 after edge T+2.
//   With i_wready held at 1, one byte per cycle: a frame is NUM_CH+4 cycles.
//  Requests arriving mid-frame set pending. The next frame starts right after CHK is accepted, following one IDLE cycle.
//  i_en=0 mid-frame: the current frame completes; the pending flag is kept.
//  Changes on i_status after the snapshot do not affect the frame in flight.
//  Reset mid-frame: frame is abandoned immediately; o_wvalid=0 asynchronously; seq returns to 0.
// TESTING
//  Use PERIOD=8, NUM_CH=2 and SYNC_BYTE=A5 for all scenarios.
//  1 Timer frame: i_en=1, i_status=16'h3412, i_wready=1.
//    -> o_wdata sequence A5,00,02,12,34,B8, 6 consecutive valid cycles.
//    -> next frame carries seq 01 and CHK B7.
//  2 Backpressure: i_wready toggles 1,0,0,1... during scenario 1.
//    -> o_wdata/o_wvalid held stable on stalled cycles; the byte sequence is unchanged.
//  3 Coalescing: i_en=0, i_wready=0, i_trig pulses at cycles 2, 5 and 9.
//    -> after the first frame: one further frame only.
//    -> o_drops=1 (the 5 pulse is pending; the 9 pulse is coalesced).
//  4 Snapshot: i_status changes to 16'hFFFF on the SEQ byte.
//    -> DATA bytes still 12,34.
//  5 Wrap/saturate: run 256 frames -> seq goes FF then 00.
//    Force 300 coalesced requests -> o_drops=FF.
//  6 Async reset: assert i_rst=0 on the DATA byte.
//    -> o_wvalid=0 and o_busy=0 immediately, before any clock edge.
//    -> after release, first frame shows seq 00 and o_drops=00.

Source files
------------

// File: rtl/debug_beacon.sv
// Periodic framed telemetry generator: SYNC, SEQ, LEN, NUM_CH status bytes, CHK.
// Frames start from a free-running period timer or an external trigger, streamed over valid/ready.
module debug_beacon #(
    parameter int unsigned PERIOD    = 8388608,
    parameter int unsigned NUM_CH    = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_trig,
    input  logic [NUM_CH*8-1:0]   i_status,
    output logic [7:0]            o_wdata,
    output logic                  o_wvalid,
    input  logic                  i_wready,
    output logic                  o_busy,
    output logic [7:0]            o_drops
);

    localparam int unsigned TW = $clog2(PERIOD);
    localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(PERIOD - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_CH - 1);
    localparam logic [7:0]    LEN_BYTE  = 8'(NUM_CH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_SEQ,
        S_LEN,
        S_DATA,
        S_CHK
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_timer;
    logic            r_pending;
    logic [7:0]      r_drops;
    logic [7:0]      r_seq;
    logic [7:0]      r_sum;
    logic [IW-1:0]   r_idx;
    logic [7:0]      r_snap [NUM_CH];

    logic            w_tick;
    logic            w_req;
    logic            w_start;
    logic            w_xfer;

    assign w_tick  = i_en && (r_timer == TIMER_MAX);
    assign w_req   = w_tick | i_trig;
    assign w_start = (r_state == S_IDLE) && r_pending;
    assign w_xfer  = o_wvalid && i_wready;
    assign o_drops = r_drops;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_timer <= '0;
        end else if (!i_en || w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TW'(1);
        end
    end

    // A request landing on the edge that consumes pending re-arms it without counting a drop.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pending <= 1'b0;
            r_drops   <= 8'h00;
        end else if (w_start) begin
            r_pending <= w_req;
        end else if (w_req) begin
            r_pending <= 1'b1;
            if (r_pending && (r_drops != 8'hFF)) begin
                r_drops <= r_drops + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (r_pending) w_next = S_SYNC;
            S_SYNC:  if (w_xfer) w_next = S_SEQ;
            S_SEQ:   if (w_xfer) w_next = S_LEN;
            S_LEN:   if (w_xfer) w_next = S_DATA;
            S_DATA:  if (w_xfer && (r_idx == LAST_IDX)) w_next = S_CHK;
            S_CHK:   if (w_xfer) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_wvalid = (r_state != S_IDLE);
        o_busy   = (r_state != S_IDLE);
        o_wdata  = 8'h00;
        case (r_state)
            S_SYNC:  o_wdata = SYNC_BYTE;
            S_SEQ:   o_wdata = r_seq;
            S_LEN:   o_wdata = LEN_BYTE;
            S_DATA:  o_wdata = r_snap[r_idx];
            S_CHK:   o_wdata = ~r_sum + 8'd1;
            default: o_wdata = 8'h00;
        endcase
    end

    // Running sum covers SEQ, LEN and DATA so that CHK makes the frame sum to zero.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_seq <= 8'h00;
            r_sum <= 8'h00;
            r_idx <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_snap[i] <= 8'h00;
            end
        end else if (w_start) begin
            r_sum <= 8'h00;
            r_idx <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_snap[i] <= i_status[i*8 +: 8];
            end
        end else if (w_xfer) begin
            case (r_state)
                S_SEQ, S_LEN: r_sum <= r_sum + o_wdata;
                S_DATA: begin
                    r_sum <= r_sum + o_wdata;
                    r_idx <= r_idx + IW'(1);
                end
                S_CHK:   r_seq <= r_seq + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_beacon.sv
// Bench for debug_beacon: directed scenarios plus random traffic, checked every cycle
// against a frame-queue reference model built from the packet rules.
module tb_debug_beacon;

    localparam int PERIOD = 8;
    localparam int NCH    = 2;

    logic        clock  = 1'b0;
    logic        resetN = 1'b0;
    logic        en     = 1'b0;
    logic        trig   = 1'b0;
    logic [15:0] status = 16'h3412;
    logic [7:0]  wdata;
    logic        wvalid;
    logic        wready = 1'b0;
    logic        busy;
    logic [7:0]  drops;

    int total = 0;
    int bad   = 0;

    logic [7:0] got [$];

    int         mTimer = 0;
    bit         mPend  = 0;
    int         mDrops = 0;
    int         mSeq   = 0;
    logic [7:0] mq [$];
    bit         mTick, mReq, mStart, mXfer;
    int         mChk;

    debug_beacon #(
        .PERIOD   (PERIOD),
        .NUM_CH   (NCH),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .i_clk    (clock),
        .i_rst    (resetN),
        .i_en     (en),
        .i_trig   (trig),
        .i_status (status),
        .o_wdata  (wdata),
        .o_wvalid (wvalid),
        .i_wready (wready),
        .o_busy   (busy),
        .o_drops  (drops)
    );

    always #5 clock = ~clock;

    // Transfers seen by the sink, in order.
    always @(posedge clock) begin
        if (wvalid && wready) got.push_back(wdata);
    end

    // Reference model: a frame is a queue of bytes built when a pending request is taken while idle.
    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            mTimer = 0;
            mPend  = 0;
            mDrops = 0;
            mSeq   = 0;
            mq.delete();
        end else begin
            mTick  = en && (mTimer == PERIOD - 1);
            mTimer = en ? (mTimer + 1) % PERIOD : 0;
            mReq   = mTick || trig;
            mStart = (mq.size() == 0) && mPend;
            mXfer  = (mq.size() != 0) && wready;
            if (mXfer) void'(mq.pop_front());
            if (mStart) begin
                mChk = (256 - ((mSeq + NCH + int'(status[7:0]) + int'(status[15:8])) % 256)) % 256;
                mq.push_back(8'hA5);
                mq.push_back(8'(mSeq));
                mq.push_back(8'(NCH));
                mq.push_back(status[7:0]);
                mq.push_back(status[15:8]);
                mq.push_back(8'(mChk));
                mSeq  = (mSeq + 1) % 256;
                mPend = mReq;
            end else if (mReq) begin
                if (mPend && mDrops < 255) mDrops++;
                mPend = 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check("valid", 32'(wvalid), 32'(mq.size() != 0));
        check("busy", 32'(busy), 32'(mq.size() != 0));
        check("drops", 32'(drops), 32'(mDrops));
        if (mq.size() != 0) check("wdata", 32'(wdata), 32'(mq[0]));
    endtask

    task automatic applyStimulus(input logic e, input logic t, input logic r);
        en     = e;
        trig   = t;
        wready = r;
        @(negedge clock);
        checkOutput();
    endtask

    task automatic doReset();
        resetN = 1'b0;
        en     = 1'b0;
        trig   = 1'b0;
        wready = 1'b0;
        @(negedge clock);
        check("rst_valid", 32'(wvalid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_drops", 32'(drops), 0);
        check("rst_wdata", 32'(wdata), 0);
        resetN = 1'b1;
        got.delete();
    endtask

    task automatic flush(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b1);
    endtask

    task automatic runUntilGot(input int n, input logic e, input logic t, input int budget, input string tag);
        int k = 0;
        while (got.size() < n && k < budget) begin
            applyStimulus(e, t, 1'b1);
            k++;
        end
        check(tag, 32'(got.size() >= n), 1);
    endtask

    logic [7:0] exp1 [12] = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hB8,
                              8'hA5, 8'h01, 8'h02, 8'h12, 8'h34, 8'hB7};

    initial begin
        int k;
        $display("[TB] start");
        doReset();

        // Timer-driven frames with a free sink.
        runUntilGot(12, 1'b1, 1'b0, 60, "s1_frames");
        for (int i = 0; i < 12; i++) check($sformatf("s1_byte%0d", i), 32'(got[i]), 32'(exp1[i]));
        flush(20);

        // Same traffic with the sink stalling two cycles out of three.
        doReset();
        k = 0;
        while (got.size() < 12 && k < 200) begin
            applyStimulus(1'b1, 1'b0, (k % 3) == 0);
            k++;
        end
        check("s2_frames", 32'(got.size() >= 12), 1);
        for (int i = 0; i < 12; i++) check($sformatf("s2_byte%0d", i), 32'(got[i]), 32'(exp1[i]));
        flush(20);

        // Coalescing with a stalled sink.
        doReset();
        for (int c = 0; c < 15; c++) applyStimulus(1'b0, (c == 2) || (c == 5) || (c == 9), 1'b0);
        check("s3_drops", 32'(drops), 1);
        flush(30);
        check("s3_count", 32'(got.size()), 12);
        check("s3_seq1", 32'(got[7]), 8'h01);

        // Status change after the snapshot.
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1);
        runUntilGot(1, 1'b0, 1'b0, 10, "s4_sync");
        status = 16'hFFFF;
        flush(10);
        check("s4_d0", 32'(got[3]), 8'h12);
        check("s4_d1", 32'(got[4]), 8'h34);
        check("s4_chk", 32'(got[5]), 8'hB8);
        status = 16'h3412;

        // Sequence wrap over 257 back-to-back frames.
        doReset();
        runUntilGot(257 * 6, 1'b0, 1'b1, 3000, "s5_frames");
        check("s5_seq0", 32'(got[1]), 8'h00);
        check("s5_seqFF", 32'(got[255 * 6 + 1]), 8'hFF);
        check("s5_seqWrap", 32'(got[256 * 6 + 1]), 8'h00);
        flush(20);

        // Drop counter saturation.
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        check("s5_dropsSat", 32'(drops), 8'hFF);
        flush(25);

        // Asynchronous reset in the middle of a DATA byte.
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1);
        flush(10);
        applyStimulus(1'b0, 1'b1, 1'b1);
        runUntilGot(9, 1'b0, 1'b0, 10, "s6_reachData");
        check("s6_inData", 32'(wvalid), 1);
        resetN = 1'b0;
        #1;
        check("s6_asyncValid", 32'(wvalid), 0);
        check("s6_asyncBusy", 32'(busy), 0);
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1);
        flush(10);
        check("s6_count", 32'(got.size()), 6);
        check("s6_seq", 32'(got[1]), 8'h00);
        check("s6_drops", 32'(drops), 0);

        // Random traffic against the model.
        doReset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) status = 16'($urandom);
            applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
        end
        flush(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
